// File: rtl/compute_max_disp_pkg.sv
// Shared sizing constants, FSM encoding and strip indexing for the block-matching disparity engine.
package compute_max_disp_pkg;

  localparam int WIN          = 15;
  localparam int DATA_SIZE    = 8;
  localparam int IMG_W        = 64;
  localparam int MAX_DISP     = 64;
  localparam int DISP_THREADS = 16;

  function automatic int sad_width(input int win, input int data_size);
    return $clog2(win * win * (2 ** data_size - 1) + 1);
  endfunction

  localparam int G          = MAX_DISP / DISP_THREADS;
  localparam int HALF       = WIN / 2;
  localparam int SAD_BITS   = sad_width(WIN, DATA_SIZE);
  localparam int DISP_BITS  = $clog2(MAX_DISP);
  localparam int COL_BITS   = $clog2(IMG_W);
  localparam int ROW_BITS   = $clog2(WIN);
  localparam int GRP_BITS   = $clog2(G + 1);
  localparam int STRIP_BITS = DATA_SIZE * IMG_W * WIN;
  localparam int IDX_BITS   = $clog2(STRIP_BITS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Pixel number of (row r, column c) inside a packed strip.
  function automatic int pix_idx(input int r, input int c);
    return r * IMG_W + c;
  endfunction

endpackage

// File: rtl/compute_max_disp_sad_row_lane.sv
// One SAD lane: WIN-term absolute-difference sum of one window row for a single disparity.
// Purely combinational; columns outside the image read as zero on both strips.
module sad_row_lane
  import compute_max_disp_pkg::*;
(
  input  logic [STRIP_BITS-1:0] i_left,
  input  logic [STRIP_BITS-1:0] i_right,
  input  logic [ROW_BITS-1:0]   i_row,
  input  logic [COL_BITS-1:0]   i_col,
  input  logic [DISP_BITS-1:0]  i_disp,
  output logic [SAD_BITS-1:0]   o_sad
);

  int                   w_xl;
  int                   w_xr;
  logic                 w_vl;
  logic                 w_vr;
  logic [IDX_BITS-1:0]  w_il;
  logic [IDX_BITS-1:0]  w_ir;
  logic [DATA_SIZE-1:0] w_pl;
  logic [DATA_SIZE-1:0] w_pr;
  logic [DATA_SIZE-1:0] w_diff;
  logic [SAD_BITS-1:0]  w_acc;

  always_comb begin
    w_acc  = '0;
    w_xl   = 0;
    w_xr   = 0;
    w_vl   = 1'b0;
    w_vr   = 1'b0;
    w_il   = '0;
    w_ir   = '0;
    w_pl   = '0;
    w_pr   = '0;
    w_diff = '0;
    for (int j = 0; j < WIN; j++) begin
      w_xl = int'(i_col) - HALF + j;
      w_xr = w_xl - int'(i_disp);
      w_vl = (w_xl >= 0) && (w_xl < IMG_W);
      w_vr = (w_xr >= 0) && (w_xr < IMG_W);
      // Index is clamped to column 0 when off-image so the select never leaves the bus.
      w_il = IDX_BITS'(pix_idx(int'(i_row), w_vl ? w_xl : 0) * DATA_SIZE);
      w_ir = IDX_BITS'(pix_idx(int'(i_row), w_vr ? w_xr : 0) * DATA_SIZE);
      w_pl = w_vl ? i_left[w_il +: DATA_SIZE] : '0;
      w_pr = w_vr ? i_right[w_ir +: DATA_SIZE] : '0;
      w_diff = (w_pl > w_pr) ? (w_pl - w_pr) : (w_pr - w_pl);
      w_acc  = w_acc + SAD_BITS'(w_diff);
    end
    o_sad = w_acc;
  end

endmodule

// File: rtl/compute_max_disp.sv
// Disparity search for one pixel: DISP_THREADS SAD lanes swept over G groups, one window row per cycle.
// Result valid G*(WIN+1)+1 cycles after the start strobe; the strips must be held stable until done.
module compute_max_disp
  import compute_max_disp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_ready,
  input  logic [COL_BITS-1:0]   col_index,
  input  logic [STRIP_BITS-1:0] input_array_L,
  input  logic [STRIP_BITS-1:0] input_array_R,
  output logic [DISP_BITS-1:0]  output_disp,
  output logic                  done
);

  state_t               r_state;
  state_t               w_next;
  logic [COL_BITS-1:0]  r_col;
  logic [ROW_BITS-1:0]  r_row;
  logic [GRP_BITS-1:0]  r_grp;
  logic [SAD_BITS-1:0]  r_acc       [DISP_THREADS];
  logic [SAD_BITS-1:0]  w_lane_sad  [DISP_THREADS];
  logic [DISP_BITS-1:0] w_lane_disp [DISP_THREADS];
  logic [SAD_BITS-1:0]  r_best_sad;
  logic [DISP_BITS-1:0] r_best_disp;
  logic [SAD_BITS-1:0]  w_min_sad;
  logic [DISP_BITS-1:0] w_min_disp;
  logic [DISP_BITS-1:0] r_disp;
  logic                 r_done;
  logic                 w_last_row;
  logic                 w_last_grp;

  for (genvar t = 0; t < DISP_THREADS; t++) begin : g_lane
    assign w_lane_disp[t] = DISP_BITS'(int'(r_grp) * DISP_THREADS + t);

    sad_row_lane u_lane (
      .i_left  (input_array_L),
      .i_right (input_array_R),
      .i_row   (r_row),
      .i_col   (r_col),
      .i_disp  (w_lane_disp[t]),
      .o_sad   (w_lane_sad[t])
    );
  end

  // Strict less-than in lane order keeps the lowest disparity on ties.
  always_comb begin
    w_min_sad  = r_acc[0];
    w_min_disp = w_lane_disp[0];
    for (int t = 1; t < DISP_THREADS; t++) begin
      if (r_acc[t] < w_min_sad) begin
        w_min_sad  = r_acc[t];
        w_min_disp = w_lane_disp[t];
      end
    end
  end

  assign w_last_row = (r_row == ROW_BITS'(WIN - 1));
  assign w_last_grp = (r_grp == GRP_BITS'(G - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (input_ready) w_next = ST_ACCUM;
      ST_ACCUM:         if (w_last_row)  w_next = ST_COMPARE;
      ST_COMPARE:       w_next = w_last_grp ? ST_DONE : ST_ACCUM;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_disp      <= '0;
      r_best_sad  <= '1;
      r_best_disp <= '0;
      r_grp       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      for (int t = 0; t < DISP_THREADS; t++) r_acc[t] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (input_ready) begin
            r_col       <= col_index;
            r_done      <= 1'b0;
            r_grp       <= '0;
            r_row       <= '0;
            r_best_sad  <= '1;
            r_best_disp <= '0;
            for (int t = 0; t < DISP_THREADS; t++) r_acc[t] <= '0;
          end else if (r_state == ST_DONE) begin
            r_done <= 1'b1;
            r_disp <= r_best_disp;
          end
        end
        ST_ACCUM: begin
          for (int t = 0; t < DISP_THREADS; t++) r_acc[t] <= r_acc[t] + w_lane_sad[t];
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end
        ST_COMPARE: begin
          if (w_min_sad < r_best_sad) begin
            r_best_sad  <= w_min_sad;
            r_best_disp <= w_min_disp;
          end
          r_grp <= r_grp + 1'b1;
          for (int t = 0; t < DISP_THREADS; t++) r_acc[t] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign output_disp = r_disp;
  assign done        = r_done;

endmodule

// File: tb/tb_compute_max_disp.sv
// Self-checking bench: random textured strips against a brute-force SAD/argmin model with a latency-level protocol model.
module tb_compute_max_disp;
  import compute_max_disp_pkg::*;

  localparam int LAT = 65;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  input_ready;
  logic [COL_BITS-1:0]   col_index;
  logic [STRIP_BITS-1:0] arr_l;
  logic [STRIP_BITS-1:0] arr_r;
  logic [DISP_BITS-1:0]  output_disp;
  logic                  done;

  int L [WIN][IMG_W];
  int R [WIN][IMG_W];
  int n_cmp = 0;
  int n_bad = 0;

  compute_max_disp dut (
    .clk           (clk),
    .rst           (rst),
    .input_ready   (input_ready),
    .col_index     (col_index),
    .input_array_L (arr_l),
    .input_array_R (arr_r),
    .output_disp   (output_disp),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix(input int img, input int r, input int c);
    if (c < 0 || c >= IMG_W) return 0;
    return (img == 0) ? L[r][c] : R[r][c];
  endfunction

  // Brute-force cost for every disparity, first minimum wins.
  function automatic int ref_disp(input int col);
    int best_cost = -1;
    int best_d    = 0;
    for (int d = 0; d < MAX_DISP; d++) begin
      int cost = 0;
      for (int r = 0; r < WIN; r++)
        for (int j = 0; j < WIN; j++) begin
          int x = col - WIN / 2 + j;
          int a = pix(0, r, x);
          int b = pix(1, r, x - d);
          cost += (a > b) ? a - b : b - a;
        end
      if (best_cost < 0 || cost < best_cost) begin
        best_cost = cost;
        best_d    = d;
      end
    end
    return best_d;
  endfunction

  // Protocol model: start when not busy (or on the cycle the result would land), result LAT edges later.
  int m_busy = 0, m_cnt = 0, m_done = 0, m_disp = 0, m_pend = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_done = 0; m_disp = 0; m_valid = 1'b1;
    end else if (m_busy != 0 && m_cnt < LAT - 1) begin
      m_cnt++;
    end else if (input_ready) begin
      m_busy = 1; m_cnt = 0; m_done = 0;
      m_pend = ref_disp(int'(col_index));
    end else if (m_busy != 0) begin
      m_busy = 0; m_done = 1; m_disp = m_pend;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("done_cyc", 32'(done), 32'(m_done));
      check("disp_cyc", 32'(output_disp), 32'(m_disp));
    end
  end

  task automatic pack_strips();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        arr_l[(r * IMG_W + c) * DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(L[r][c]);
        arr_r[(r * IMG_W + c) * DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(R[r][c]);
      end
  endtask

  // mode 0: textured L, R = L shifted by s; mode 1: all zero; mode 2: as 0 with L blanked just left of the last column.
  task automatic make_strips(input int s, input int mode);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        L[r][c] = (mode == 1) ? 0 : int'($urandom_range(255, 1));
        if (mode == 2 && c >= IMG_W - 1 - WIN / 2 && c < IMG_W - 1) L[r][c] = 0;
      end
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        R[r][c] = (c + s < IMG_W) ? L[r][c + s] : 0;
    pack_strips();
  endtask

  task automatic run(input string name, input int col, input int exp, input int mid);
    int cyc;
    bit got;
    col_index   = COL_BITS'(col);
    input_ready = 1'b1;
    if (exp >= 0) check({name, "_model"}, 32'(ref_disp(col)), 32'(exp));
    @(posedge clk); #1;
    input_ready = 1'b0;
    check({name, "_fall"}, 32'(done), 32'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (cyc == mid) begin
        input_ready = 1'b1;
        col_index   = COL_BITS'(col ^ 5);
      end else begin
        input_ready = 1'b0;
      end
      if (done === 1'b1) got = 1'b1;
    end
    input_ready = 1'b0;
    check({name, "_lat"}, 32'(cyc), 32'(LAT));
    if (exp >= 0) check({name, "_disp"}, 32'(output_disp), 32'(exp));
  endtask

  initial begin
    rst         = 1'b1;
    input_ready = 1'b1;
    col_index   = COL_BITS'(7);
    make_strips(3, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_disp", 32'(output_disp), 32'd0);
    rst         = 1'b0;
    input_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle_done", 32'(done), 32'd0);

    make_strips(5, 0);   run("shift5",   40, 5,  0);
    make_strips(0, 0);   run("ident",    32, 0,  0);
    make_strips(0, 1);   run("zero",     32, 0,  0);
    make_strips(37, 0);  run("shift37",  50, 37, 0);
    make_strips(48, 0);  run("shift48",  60, 48, 0);
    make_strips(63, 2);  run("shift63",  63, 63, 0);
    make_strips(12, 0);  run("midpulse", 30, 12, 20);
    make_strips(20, 0);  run("restart",  40, 20, 0);

    make_strips(9, 0);
    col_index   = COL_BITS'(30);
    input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_disp", 32'(output_disp), 32'd0);
    repeat (80) @(posedge clk);
    #1;
    check("midrst_idle", 32'(done), 32'd0);

    for (int k = 0; k < 6; k++) begin
      make_strips(int'($urandom_range(63, 0)), 0);
      run("rand", int'($urandom_range(63, 0)), -1, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/compute_max_disp.md
Name: compute_max_disp

Overview:
- Stereo block-matching disparity engine for one pixel.
- Inputs: a WIN-row strip of the left and the right image.
- Computes a sum-of-absolute-differences (SAD) cost for every candidate disparity 0..MAX_DISP-1 at column col_index, and returns the disparity with minimum cost.
- Disparities are evaluated in MAX_DISP/DISP_THREADS sequential groups of DISP_THREADS parallel SAD lanes.
- Sits between the line-buffer/strip-packer and the disparity-map writer.

Parameters:
- WIN, 15: window height and width in pixels; odd, ≥3.
- DATA_SIZE, 8: bits per pixel, unsigned.
- IMG_W, 64: pixels per image row.
- MAX_DISP, 64: number of candidate disparities; power of two.
- DISP_THREADS, 16: parallel SAD lanes; must divide MAX_DISP.
- Derived constants:
  - G = MAX_DISP/DISP_THREADS
  - HALF = WIN/2
  - SAD_BITS = clog2(WIN*WIN*(2^DATA_SIZE-1)+1), 16 at defaults
  - DISP_BITS = clog2(MAX_DISP)
  - COL_BITS = clog2(IMG_W)

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- input_ready, in, 1: start strobe, one cycle.
- col_index, in, COL_BITS: target column.
- input_array_L, in, DATA_SIZE*IMG_W*WIN: left strip. Pixel (row r, col c) is at bits [(r*IMG_W+c)*DATA_SIZE +: DATA_SIZE].
- input_array_R, in, same width and packing: right strip.
- output_disp, out, DISP_BITS: winning disparity.
- done, out, 1: result valid.

Behaviour:
- Reset (rst high at a clock edge, any state, including mid-computation):
  - state=IDLE, done=0, output_disp=0, best SAD = all ones, group counter and row counter = 0.
  - Any in-progress computation is abandoned.
- Cost for disparity d:
  - SAD(d) = sum over r=0..WIN-1 and j=0..WIN-1 of |L[r][x] - R[r][x-d]|, where x = col_index - HALF + j.
  - Any pixel whose column is <0 or ≥IMG_W reads as 0, on either image.
  - Differences are unsigned absolute values; accumulate at SAD_BITS, which cannot overflow.
- Inputs:
  - col_index is registered when input_ready is sampled.
  - input_array_L and input_array_R are not latched; the source holds them stable from the input_ready cycle until done rises.
- FSM states: IDLE, ACCUM, COMPARE, DONE.
  - IDLE, or DONE, with input_ready=1:
    - latch col_index, clear done, g=0, r=0, best SAD = all ones, best disparity = 0;
    - go to ACCUM.
    - input_ready in ACCUM or COMPARE is ignored.
  - ACCUM:
    - each lane t (0..DISP_THREADS-1) evaluates d = g*DISP_THREADS+t;
    - each cycle, each lane adds the WIN absolute differences of row r to its accumulator (zeroed on entry to the group);
    - r increments; after r=WIN-1, go to COMPARE.
  - COMPARE:
    - scan lanes t=0..DISP_THREADS-1 in order (combinational min tree allowed);
    - replace best when SAD < best (strict), so ties keep the smallest disparity;
    - g increments; if g==G go to DONE, else go to ACCUM with r=0.
  - DONE:
    - done=1 and output_disp=best disparity, both held until rst or a new input_ready.
- Latency: done is high exactly G*(WIN+1)+1 rising edges after the edge sampling input_ready (65 at defaults).

Decomposition:
- Shared package compute_max_disp_pkg holds:
  - derived width functions and constants (SAD_BITS, DISP_BITS, COL_BITS);
  - the FSM state enum;
  - the pixel-index helper (r*IMG_W+c).
- One sub-module, sad_row_lane, per lane. Combinational: given row r, column base x0 and disparity d, it returns the WIN-term absolute-difference sum with zero-padding at the image edges.
- The top module instantiates DISP_THREADS lanes plus the accumulators, FSM and min-select.

Test Plan:
- Reset:
  - hold rst for 2 cycles;
  - required: done=0 and output_disp=0;
  - input_ready during rst is ignored.
- Shift 5:
  - random texture with R[r][c] = L[r][c+5], col_index=40, pulse input_ready;
  - required: done=1 after exactly 65 cycles, output_disp=5.
- Identical images:
  - random L=R, col_index=32;
  - required: output_disp=0.
  - Then all-zero L and R: every SAD is 0, tie, so output_disp=0.
- Cross-group disparities:
  - shift 37 at col_index=50: required 37 (group 2, lane 5);
  - shift 48 at col_index=60: required 48;
  - shift 63 with textured L, col_index=63: required 63.
- Protocol:
  - pulse input_ready again mid-computation: required no restart, same latency;
  - pulse input_ready while done=1 with a new strip: done falls next cycle, new result after 65 cycles;
  - assert rst mid-computation: done stays 0, output_disp=0.
